mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Request-side controller for the unified single-port instruction/data memory. Arbitrates between the fetch stage and the load/store stage, converts each granted request into the memory's command signals (flag, read, write, size, extension select), captures the combinational read data and returns it with a valid pulse. It sits between the pipeline and the memory, so only one access reaches the memory per access cycle.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive data grants allowed while a fetch is pending; must be 1 or more.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request, held until accepted.
- `if_addr` in 32: fetch byte address.
- `if_ready` out 1: fetch request accepted this cycle.
- `if_valid` out 1: one-cycle pulse, `if_rdata` valid.
- `if_rdata` out 32: fetched instruction word.
- `d_req` in 1: data request, held until accepted.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 00 = byte, 01 = half, 10 = word.
- `d_unsigned` in 1: 1 = LBU/LHU zero extension.
- `d_addr` in 32: data byte address, data-region relative.
- `d_wdata` in 32: store data, right-aligned.
- `d_ready` out 1: data request accepted this cycle.
- `d_valid` out 1: one-cycle pulse, load data valid or store done.
- `d_rdata` out 32: load result; 0 for stores.
- `d_err` out 1: misaligned access; valid with `d_valid`.
- `mem_flag` out 1: 1 = instruction fetch.
- `mem_read` out 1, `mem_write` out 1: data access strobes.
- `mem_addr` out 32, `mem_wdata` out 32: address and store data.
- `mem_loadbyte` out 1, `mem_loadhalf` out 1: size encoding 10 = byte, 01 = half, 00 = word.
- `mem_signedmem` out 1: 1 = zero-extend, 0 = sign-extend. This follows the memory's polarity.
- `mem_rdata` in 32: combinational read data from the memory.

## Operation
- States are IDLE and ACCESS.
- In IDLE with no request, all `mem_*` outputs are 0.
- **Grant in IDLE.**
  - Grant `d_req` over `if_req`, unless `starve_cnt` equals `STARVE_LIMIT` and `if_req` is high; then grant the fetch.
  - Pulse the winner's `*_ready` combinationally in IDLE.
  - Latch the winner's command into the `mem_*` registers and go to ACCESS.
- **ACCESS.**
  - Exactly one of `mem_flag`, `mem_read`, `mem_write` is high.
  - A fetch drives `mem_flag`=1 with size bits 00.
  - A store drives `mem_write`=1, `mem_wdata`=`d_wdata`, and size bits from `d_size`.
  - A load drives `mem_read`=1, size bits, and `mem_signedmem`=`d_unsigned`.
  - At the end of the cycle, capture `mem_rdata` (0 for a store) into `if_rdata` or `d_rdata`, clear all `mem_*`, and return to IDLE.
- **Response.** In the cycle after ACCESS, pulse `if_valid` or `d_valid`. A new grant is allowed in that same IDLE cycle.
- **Starvation counter `starve_cnt`.**
  - Width is clog2(STARVE_LIMIT+1).
  - Increments on a data grant while `if_req` is high; saturates at `STARVE_LIMIT`.
  - Clears on any fetch grant, and on a data grant while `if_req` is low.
- `*_rdata` holds its value until the next response on that channel.
- **Reset.** State IDLE, `starve_cnt` 0, and every output 0, including `*_rdata`.
  - Reset during ACCESS drops the access with no valid pulse.
  - A write in flight may already have reached the memory, because its write path is level-sensitive.

## Timing
- Request seen in cycle N (IDLE, granted): command on `mem_*` in N+1; `*_valid` and data in N+2.
- Throughput is one access per 2 cycles at best.
- All `mem_*` outputs are registered, so address and data are stable for the whole cycle `mem_write` is high.
- A request held across a lost arbitration cycle is served later with no other side effects.
- Simultaneous `if_req` and `d_req` give a data grant unless the starve limit has been reached.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A data request is misaligned when it is a half with `d_addr[0]`=1, or a word with `d_addr[1:0]`≠0.
  - A misaligned request is accepted but never issued: `mem_*` stay 0 for that access.
  - `d_valid`=1, `d_err`=1 and `d_rdata`=0 appear 2 cycles after the request, the same as a normal access.
  - The grant still counts toward `starve_cnt`.
- Not defined: misaligned requests are passed to the memory unchanged, and `d_err` is tied to 0.

## Test plan
- **Fetch latency.** Reset, then `if_req`=1, `if_addr`=0x4 -> `mem_flag`=1 and `mem_addr`=0x4 in cycle 1; `if_valid`=1 with `if_rdata`=0x01900093 in cycle 2.
- **Store then load.** Store word 0x12345678 to `d_addr`=0, then load the word -> `mem_write` is one cycle with size bits 00; the load returns `d_rdata`=0x12345678.
- **Byte load extension.** Store byte 0x80, then LB (`d_unsigned`=0) -> `mem_signedmem`=0 and 0xFFFFFF80. LBU (`d_unsigned`=1) -> `mem_signedmem`=1 and 0x00000080.
- **Starvation.** `if_req` and `d_req` held high with `STARVE_LIMIT`=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- **Reset mid-access.** Assert `rst` in ACCESS of a load -> no `d_valid`; all outputs 0 the next cycle; a fresh request is served normally.
- **Misaligned trap** (`MISALIGN_TRAP_EN` defined). Word load at `d_addr`=0x2 -> `mem_read` never high; `d_valid`=1, `d_err`=1, `d_rdata`=0 two cycles after the request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter for the unified single-port memory: one registered access per grant,
// response one cycle later. Optional MISALIGN_TRAP_EN turns misaligned data accesses into error responses.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_flag,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_loadbyte,
  output logic        mem_loadhalf,
  output logic        mem_signedmem,
  input  logic [31:0] mem_rdata,
  output logic        dbg_state
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] LIMIT_C = SCW'(STARVE_LIMIT);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [SCW-1:0]  starve_cnt_q, starve_cnt_d;
  logic            acc_fetch_q, acc_fetch_d;
  logic            acc_store_q, acc_store_d;
  logic            acc_err_q, acc_err_d;

  logic            mem_flag_q, mem_flag_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            mem_loadbyte_q, mem_loadbyte_d;
  logic            mem_loadhalf_q, mem_loadhalf_d;
  logic            mem_signedmem_q, mem_signedmem_d;

  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic            d_valid_q, d_valid_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            d_err_q, d_err_d;

  logic            fetch_win;
  logic            data_win;
  logic            misalign;

  // Handshake: a request is held until its *_ready pulses in an IDLE cycle; the matching
  // *_valid pulses exactly two cycles after that acceptance (unless reset intervenes).
  assign fetch_win = if_req && (!d_req || (starve_cnt_q == LIMIT_C));
  assign data_win  = d_req && !fetch_win;

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((d_size == 2'b01) && d_addr[0]) || (d_size[1] && (d_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    starve_cnt_d    = starve_cnt_q;
    acc_fetch_d     = acc_fetch_q;
    acc_store_d     = acc_store_q;
    acc_err_d       = acc_err_q;
    mem_flag_d      = mem_flag_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_loadbyte_d  = mem_loadbyte_q;
    mem_loadhalf_d  = mem_loadhalf_q;
    mem_signedmem_d = mem_signedmem_q;
    if_valid_d      = 1'b0;
    if_rdata_d      = if_rdata_q;
    d_valid_d       = 1'b0;
    d_rdata_d       = d_rdata_q;
    d_err_d         = 1'b0;
    if_ready        = 1'b0;
    d_ready         = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_win) begin
          if_ready        = !rst;
          acc_fetch_d     = 1'b1;
          acc_store_d     = 1'b0;
          acc_err_d       = 1'b0;
          mem_flag_d      = 1'b1;
          mem_read_d      = 1'b0;
          mem_write_d     = 1'b0;
          mem_addr_d      = if_addr;
          mem_wdata_d     = 32'h0;
          mem_loadbyte_d  = 1'b0;
          mem_loadhalf_d  = 1'b0;
          mem_signedmem_d = 1'b0;
          starve_cnt_d    = '0;
          state_d         = ACCESS;
        end else if (data_win) begin
          d_ready     = !rst;
          acc_fetch_d = 1'b0;
          acc_store_d = d_we;
          acc_err_d   = misalign;
          // A trapped access never touches the memory; the mem_* registers stay cleared.
          if (!misalign) begin
            mem_flag_d      = 1'b0;
            mem_read_d      = !d_we;
            mem_write_d     = d_we;
            mem_addr_d      = d_addr;
            mem_wdata_d     = d_we ? d_wdata : 32'h0;
            mem_loadbyte_d  = (d_size == 2'b00);
            mem_loadhalf_d  = (d_size == 2'b01);
            mem_signedmem_d = !d_we && d_unsigned;
          end
          if (!if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_flag_d      = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_addr_d      = 32'h0;
        mem_wdata_d     = 32'h0;
        mem_loadbyte_d  = 1'b0;
        mem_loadhalf_d  = 1'b0;
        mem_signedmem_d = 1'b0;
        if (acc_fetch_q) begin
          if_rdata_d = mem_rdata;
          if_valid_d = 1'b1;
        end else begin
          d_rdata_d = (acc_store_q || acc_err_q) ? 32'h0 : mem_rdata;
          d_valid_d = 1'b1;
          d_err_d   = acc_err_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      starve_cnt_q    <= '0;
      acc_fetch_q     <= 1'b0;
      acc_store_q     <= 1'b0;
      acc_err_q       <= 1'b0;
      mem_flag_q      <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_addr_q      <= 32'h0;
      mem_wdata_q     <= 32'h0;
      mem_loadbyte_q  <= 1'b0;
      mem_loadhalf_q  <= 1'b0;
      mem_signedmem_q <= 1'b0;
      if_valid_q      <= 1'b0;
      if_rdata_q      <= 32'h0;
      d_valid_q       <= 1'b0;
      d_rdata_q       <= 32'h0;
      d_err_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      starve_cnt_q    <= starve_cnt_d;
      acc_fetch_q     <= acc_fetch_d;
      acc_store_q     <= acc_store_d;
      acc_err_q       <= acc_err_d;
      mem_flag_q      <= mem_flag_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_loadbyte_q  <= mem_loadbyte_d;
      mem_loadhalf_q  <= mem_loadhalf_d;
      mem_signedmem_q <= mem_signedmem_d;
      if_valid_q      <= if_valid_d;
      if_rdata_q      <= if_rdata_d;
      d_valid_q       <= d_valid_d;
      d_rdata_q       <= d_rdata_d;
      d_err_q         <= d_err_d;
    end
  end

  assign mem_flag      = mem_flag_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_loadbyte  = mem_loadbyte_q;
  assign mem_loadhalf  = mem_loadhalf_q;
  assign mem_signedmem = mem_signedmem_q;
  assign if_valid      = if_valid_q;
  assign if_rdata      = if_rdata_q;
  assign d_valid       = d_valid_q;
  assign d_rdata       = d_rdata_q;
  assign d_err         = d_err_q;
  assign dbg_state     = (state_q == ACCESS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-addressed memory model on the mem_* side.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_flag;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_loadbyte;
  logic        mem_loadhalf;
  logic        mem_signedmem;
  logic [31:0] mem_rdata;
  logic        dbg_state;

  int n_vec;
  int n_err;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_flag(mem_flag), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_loadbyte(mem_loadbyte),
    .mem_loadhalf(mem_loadhalf), .mem_signedmem(mem_signedmem),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fixed instruction image, byte-addressed data region (signedmem=1 -> zero-extend).
  logic [7:0] dmem [256];
  logic [7:0] ra;
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    ra = mem_addr[7:0];
    b0 = dmem[ra];
    b1 = dmem[ra + 8'd1];
    b2 = dmem[ra + 8'd2];
    b3 = dmem[ra + 8'd3];
    mem_rdata = 32'h0;
    if (mem_flag) begin
      mem_rdata = (mem_addr == 32'h4) ? 32'h01900093 : {16'hC0DE, mem_addr[15:0]};
    end else if (mem_read) begin
      if (mem_loadbyte)
        mem_rdata = mem_signedmem ? {24'h0, b0} : {{24{b0[7]}}, b0};
      else if (mem_loadhalf)
        mem_rdata = mem_signedmem ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      else
        mem_rdata = {b3, b2, b1, b0};
    end
  end

  always @(posedge clk) begin
    if (mem_write) begin
      dmem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (!mem_loadbyte) dmem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (!mem_loadbyte && !mem_loadhalf) begin
        dmem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        dmem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data);
    if_req  = 1'b1;
    if_addr = addr;
    #1;
    check("f_ready", {31'h0, if_ready}, 32'h1);
    tick();
    if_req = 1'b0;
    check("f_flag", {31'h0, mem_flag}, 32'h1);
    check("f_addr", mem_addr, addr);
    check("f_size", {30'h0, mem_loadbyte, mem_loadhalf}, 32'h0);
    check("f_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    check("f_valid_early", {31'h0, if_valid}, 32'h0);
    tick();
    check("f_valid", {31'h0, if_valid}, 32'h1);
    check("f_rdata", if_rdata, exp_data);
    check("f_idle_flag", {31'h0, mem_flag}, 32'h0);
  endtask

  task automatic do_data(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] exp_sz, input logic exp_signed,
                         input logic [31:0] exp_rdata);
    d_req      = 1'b1;
    d_we       = we;
    d_size     = size;
    d_unsigned = uns;
    d_addr     = addr;
    d_wdata    = wdata;
    #1;
    check("d_ready", {31'h0, d_ready}, 32'h1);
    check("d_if_ready", {31'h0, if_ready}, 32'h0);
    tick();
    d_req = 1'b0;
    check("d_read", {31'h0, mem_read}, {31'h0, !we});
    check("d_write", {31'h0, mem_write}, {31'h0, we});
    check("d_flag", {31'h0, mem_flag}, 32'h0);
    check("d_addr", mem_addr, addr);
    check("d_wdata", mem_wdata, we ? wdata : 32'h0);
    check("d_size", {30'h0, mem_loadbyte, mem_loadhalf}, {30'h0, exp_sz});
    check("d_signedmem", {31'h0, mem_signedmem}, {31'h0, exp_signed});
    tick();
    check("d_valid", {31'h0, d_valid}, 32'h1);
    check("d_rdata", d_rdata, exp_rdata);
    check("d_err", {31'h0, d_err}, 32'h0);
    check("d_idle_write", {31'h0, mem_write}, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_state", {31'h0, dbg_state}, 32'h0);
    check("rst_mem", {26'h0, mem_flag, mem_read, mem_write, mem_loadbyte, mem_loadhalf, mem_signedmem}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_valids", {29'h0, if_valid, d_valid, d_err}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);

    // Fetch latency
    do_fetch(32'h4, 32'h01900093);

    // Store word then load word (size bits 00 = word)
    do_data(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678, 2'b00, 1'b0, 32'h0);
    do_data(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h12345678);

    // Byte store 0x80, LB sign-extends, LBU zero-extends; then a half load
    do_data(1'b1, 2'b00, 1'b0, 32'h8, 32'hAABBCC80, 2'b10, 1'b0, 32'h0);
    do_data(1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 32'hFFFFFF80);
    do_data(1'b0, 2'b00, 1'b1, 32'h8, 32'h0, 2'b10, 1'b1, 32'h00000080);
    do_data(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 2'b01, 1'b0, 32'h00001234);

    // Starvation: both held high, expect D,D,D,D,F,D,D,D,D,F
    if_req = 1'b1; if_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 32'h0;
    #1;
    for (int i = 0; i < 10; i++) begin
      logic exp_f;
      exp_f = ((i % 5) == 4);
      check("starve_if_ready", {31'h0, if_ready}, {31'h0, exp_f});
      check("starve_d_ready", {31'h0, d_ready}, {31'h0, !exp_f});
      tick();
      check("starve_acc_ready", {30'h0, if_ready, d_ready}, 32'h0);
      tick();
      check("starve_resp", {30'h0, if_valid, d_valid}, exp_f ? 32'h2 : 32'h1);
    end
    if_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();

    // Reset in ACCESS of a load drops the response
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0;
    #1;
    check("rma_ready", {31'h0, d_ready}, 32'h1);
    tick();
    d_req = 1'b0;
    check("rma_read", {31'h0, mem_read}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rma_valid", {31'h0, d_valid}, 32'h0);
    check("rma_mem", {29'h0, mem_flag, mem_read, mem_write}, 32'h0);
    check("rma_state", {31'h0, dbg_state}, 32'h0);
    check("rma_d_rdata", d_rdata, 32'h0);
    check("rma_if_rdata", if_rdata, 32'h0);
    tick();
    check("rma_valid_late", {31'h0, d_valid}, 32'h0);
    do_data(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h12345678);
    do_fetch(32'h10, 32'hC0DE0010);

    // Misaligned word load at 0x2
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 32'h2;
    #1;
    check("mis_ready", {31'h0, d_ready}, 32'h1);
    tick();
    d_req = 1'b0;
`ifdef MISALIGN_TRAP_EN
    check("mis_mem", {29'h0, mem_flag, mem_read, mem_write}, 32'h0);
    check("mis_addr", mem_addr, 32'h0);
    tick();
    check("mis_valid", {31'h0, d_valid}, 32'h1);
    check("mis_err", {31'h0, d_err}, 32'h1);
    check("mis_rdata", d_rdata, 32'h0);
`else
    check("mis_mem", {29'h0, mem_flag, mem_read, mem_write}, 32'h2);
    check("mis_addr", mem_addr, 32'h2);
    tick();
    check("mis_valid", {31'h0, d_valid}, 32'h1);
    check("mis_err", {31'h0, d_err}, 32'h0);
`endif
    tick();
    check("mis_err_clear", {30'h0, d_valid, d_err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
